// File: rtl/clm_sbox_scheduler.sv
// clm_sbox_scheduler: time-multiplexes NUM_SBOX CLM S-box lanes over one round's byte jobs.
// Define CLM_SBOX_SCHED_KEY_EN to schedule the 4 key-expansion bytes ahead of the 16 state bytes.
module clm_sbox_scheduler #(
    parameter int d        = 4,
    parameter int NUM_SBOX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [16*(8+d)-1:0]       state_in,
    input  logic [4*(8+d)-1:0]        key_in,
    output logic [NUM_SBOX*(8+d)-1:0] sbox_in,
    output logic [NUM_SBOX*5-1:0]     sbox_shamt,
    output logic [NUM_SBOX-1:0]       sbox_drdy_i,
    input  logic [NUM_SBOX-1:0]       sbox_drdy_o,
    input  logic [NUM_SBOX*(8+d)-1:0] sbox_out,
    output logic [16*(8+d)-1:0]       state_out,
    output logic [4*(8+d)-1:0]        key_out,
    output logic                      busy,
    output logic                      done
);
    localparam int W = 8 + d;
`ifdef CLM_SBOX_SCHED_KEY_EN
    localparam int KJ = 4;
`else
    localparam int KJ = 0;
`endif
    localparam int JOBS = 16 + KJ;
    localparam int B    = (JOBS + NUM_SBOX - 1) / NUM_SBOX;
    localparam int BW   = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                fsm;
    logic [BW-1:0]         batch;
    logic [BW-1:0]         issue_batch;
    logic [NUM_SBOX-1:0]   act;
    logic [NUM_SBOX-1:0]   seen;
    logic [NUM_SBOX-1:0]   seen_next;
    logic [NUM_SBOX-1:0]   capture;
    logic [NUM_SBOX-1:0]   issue_act;
    logic [W-1:0]          op_src   [JOBS];
    logic [W-1:0]          op_buf   [JOBS];
    logic [W-1:0]          res      [JOBS];
    logic [W-1:0]          res_next [JOBS];
    logic [NUM_SBOX*W-1:0] issue_in;
    logic [NUM_SBOX*5-1:0] issue_shamt;
    logic [16*W-1:0]       state_pack;
    logic [4*W-1:0]        key_pack;
    logic                  all_seen;
    logic                  last_batch;

    function automatic logic [4:0] job_shamt(input int unsigned j);
`ifdef CLM_SBOX_SCHED_KEY_EN
        return (j < 4) ? 5'(16 + j) : 5'(j - 4);
`else
        return 5'(j);
`endif
    endfunction

    // Operands are kept in job order so batch/lane decode is a pure function of job index.
    always_comb begin
        op_src = '{default: '0};
`ifdef CLM_SBOX_SCHED_KEY_EN
        for (int unsigned m = 0; m < 4; m++)
            op_src[m] = key_in[m*W +: W];
`endif
        for (int unsigned k = 0; k < 16; k++)
            op_src[KJ+k] = state_in[k*W +: W];
    end

    // Lane values for the batch about to be issued; taken straight from the inputs on start.
    assign issue_batch = (fsm == IDLE) ? '0 : BW'(batch + BW'(1));

    always_comb begin
        issue_in    = '0;
        issue_shamt = '0;
        issue_act   = '0;
        for (int unsigned j = 0; j < JOBS; j++) begin
            if (issue_batch == BW'(j / NUM_SBOX)) begin
                issue_act[j % NUM_SBOX]               = 1'b1;
                issue_in[(j % NUM_SBOX)*W +: W]       = (fsm == IDLE) ? op_src[j] : op_buf[j];
                issue_shamt[(j % NUM_SBOX)*5 +: 5]    = job_shamt(j);
            end
        end
    end

    assign capture    = (fsm == WAIT) ? (sbox_drdy_o & act & ~seen) : '0;
    assign seen_next  = seen | capture;
    assign all_seen   = (seen_next == act);
    assign last_batch = (batch == BW'(B - 1));

    always_comb begin
        res_next = res;
        for (int unsigned j = 0; j < JOBS; j++) begin
            if (batch == BW'(j / NUM_SBOX) && capture[j % NUM_SBOX])
                res_next[j] = sbox_out[(j % NUM_SBOX)*W +: W];
        end
    end

    always_comb begin
        state_pack = '0;
        for (int unsigned k = 0; k < 16; k++)
            state_pack[k*W +: W] = res_next[KJ+k];
    end

`ifdef CLM_SBOX_SCHED_KEY_EN
    always_comb begin
        key_pack = '0;
        for (int unsigned m = 0; m < 4; m++)
            key_pack[m*W +: W] = res_next[m];
    end
`else
    assign key_pack = '0;
    logic unused_key;
    assign unused_key = ^key_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            batch       <= '0;
            act         <= '0;
            seen        <= '0;
            op_buf      <= '{default: '0};
            res         <= '{default: '0};
            sbox_in     <= '0;
            sbox_shamt  <= '0;
            sbox_drdy_i <= '0;
            state_out   <= '0;
            key_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            sbox_drdy_i <= '0;
            done        <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        op_buf      <= op_src;
                        batch       <= '0;
                        busy        <= 1'b1;
                        sbox_in     <= issue_in;
                        sbox_shamt  <= issue_shamt;
                        sbox_drdy_i <= issue_act;
                        act         <= issue_act;
                        fsm         <= ISSUE;
                    end
                end
                ISSUE: begin
                    seen <= '0;
                    fsm  <= WAIT;
                end
                WAIT: begin
                    seen <= seen_next;
                    res  <= res_next;
                    if (all_seen) begin
                        if (last_batch) begin
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            sbox_in    <= '0;
                            sbox_shamt <= '0;
                            act        <= '0;
                            state_out  <= state_pack;
                            key_out    <= key_pack;
                            fsm        <= DONE;
                        end else begin
                            batch       <= batch + BW'(1);
                            sbox_in     <= issue_in;
                            sbox_shamt  <= issue_shamt;
                            sbox_drdy_i <= issue_act;
                            act         <= issue_act;
                            fsm         <= ISSUE;
                        end
                    end
                end
                DONE:    fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clm_sbox_scheduler.sv
// Bench for clm_sbox_scheduler: randomized runs against a job-level reference model with
// behavioural S-box lanes (per-lane latency, duplicate pulses, stray pulses, mid-run reset).
module tb_clm_sbox_scheduler;
    localparam int W = 12;
    localparam int N = 3;
`ifdef CLM_SBOX_SCHED_KEY_EN
    localparam int KJ = 4;
`else
    localparam int KJ = 0;
`endif
    localparam int JOBS = 16 + KJ;
    localparam int B    = (JOBS + N - 1) / N;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [16*W-1:0] state_in = '0;
    logic [4*W-1:0]  key_in = '0;
    logic [N*W-1:0]  sbox_in;
    logic [N*5-1:0]  sbox_shamt;
    logic [N-1:0]    sbox_drdy_i;
    logic [N-1:0]    sbox_drdy_o = '0;
    logic [N*W-1:0]  sbox_out = '0;
    logic [16*W-1:0] state_out;
    logic [4*W-1:0]  key_out;
    logic            busy;
    logic            done;

    clm_sbox_scheduler #(.d(4), .NUM_SBOX(N)) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in), .key_in(key_in),
        .sbox_in(sbox_in), .sbox_shamt(sbox_shamt), .sbox_drdy_i(sbox_drdy_i),
        .sbox_drdy_o(sbox_drdy_o), .sbox_out(sbox_out), .state_out(state_out),
        .key_out(key_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [16*W-1:0] got, input logic [16*W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sbox(input logic [W-1:0] x, input logic [4:0] s);
        logic [W-1:0] t;
        t = W'(x * 29) ^ {7'h3A, s};
        return t + W'(s) + W'(1);
    endfunction

    // Reference job list: key bytes first (when enabled), then state bytes.
    logic [W-1:0] st_b [16];
    logic [W-1:0] ky_b [4];

    function automatic logic [W-1:0] job_op(input int j);
        return (j < KJ) ? ky_b[j] : st_b[j-KJ];
    endfunction

    function automatic logic [4:0] job_sh(input int j);
        return (j < KJ) ? 5'(16 + j) : 5'(j - KJ);
    endfunction

    // Behavioural S-box lanes
    int           lat [N];
    int           cnt [N];
    logic [W-1:0] op_l [N];
    logic [4:0]   sh_l [N];
    bit           dup_pend [N];
    bit           dup_en = 0;
    bit           noise_en = 0;
    int           bidx = 0;
    int           issues = 0;

    always @(negedge clk) begin
        sbox_drdy_o = '0;
        for (int l = 0; l < N; l++) begin
            if (cnt[l] > 0) begin
                cnt[l]--;
                if (cnt[l] == 0) begin
                    sbox_drdy_o[l]     = 1'b1;
                    sbox_out[l*W +: W] = ref_sbox(op_l[l], sh_l[l]);
                    dup_pend[l]        = dup_en && (l == 0);
                end
            end else if (dup_pend[l]) begin
                sbox_drdy_o[l]     = 1'b1;
                sbox_out[l*W +: W] = ~ref_sbox(op_l[l], sh_l[l]);
                dup_pend[l]        = 0;
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                sbox_drdy_o[l]     = 1'b1;
                sbox_out[l*W +: W] = W'($urandom);
            end
        end
        if (|sbox_drdy_i) begin
            issues++;
            for (int l = 0; l < N; l++) begin
                int job;
                job = bidx * N + l;
                check("lane_drdy_i", sbox_drdy_i[l], job < JOBS);
                if (job < JOBS) begin
                    check("lane_sbox_in", sbox_in[l*W +: W], job_op(job));
                    check("lane_shamt", sbox_shamt[l*5 +: 5], job_sh(job));
                end else begin
                    check("unused_lane_in", sbox_in[l*W +: W], 0);
                end
                if (sbox_drdy_i[l]) begin
                    op_l[l] = sbox_in[l*W +: W];
                    sh_l[l] = sbox_shamt[l*5 +: 5];
                    cnt[l]  = lat[l];
                    if (noise_en) begin
                        sbox_drdy_o[l]     = 1'b1;
                        sbox_out[l*W +: W] = W'($urandom);
                    end
                end
            end
            bidx++;
        end
    end

    task automatic load_inputs();
        for (int k = 0; k < 16; k++) state_in[k*W +: W] = st_b[k];
        for (int m = 0; m < 4; m++)  key_in[m*W +: W]   = ky_b[m];
    endtask

    task automatic rand_data();
        for (int k = 0; k < 16; k++) st_b[k] = W'($urandom);
        for (int m = 0; m < 4; m++)  ky_b[m] = W'($urandom);
    endtask

    task automatic check_results(input string tag);
        logic [16*W-1:0] es;
        logic [4*W-1:0]  ek;
        es = '0;
        ek = '0;
        for (int k = 0; k < 16; k++) es[k*W +: W] = ref_sbox(st_b[k], 5'(k));
        for (int m = 0; m < KJ; m++) ek[m*W +: W] = ref_sbox(ky_b[m], 5'(16 + m));
        check({tag, "_state_out"}, state_out, es);
        check({tag, "_key_out"}, key_out, ek);
    endtask

    task automatic run_job(input bit extra_start);
        int  k;
        int  exp_k;
        int  iss0;
        bit  seen;
        load_inputs();
        exp_k = 1;
        for (int b = 0; b < B; b++) begin
            int mx;
            mx = 0;
            for (int l = 0; l < N; l++)
                if (b * N + l < JOBS && lat[l] > mx) mx = lat[l];
            exp_k += mx + 1;
        end
        bidx = 0;
        iss0 = issues;
        @(negedge clk);
        start = 1'b1;
        k = 0;
        seen = 0;
        while (!seen && k < exp_k + 40) begin
            @(negedge clk);
            k++;
            start = extra_start && (k == 3);
            if (k == 1) check("busy_in_issue", busy, 1);
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("done_latency", k, exp_k);
        check("busy_at_done", busy, 0);
        check("sbox_in_at_done", sbox_in, 0);
        check("drdy_i_at_done", sbox_drdy_i, 0);
        check_results("done");
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_shamt", sbox_shamt, 0);
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);
        check("issue_count", issues - iss0, B);
        check_results("hold");
    endtask

    task automatic reset_mid_run();
        rand_data();
        load_inputs();
        for (int l = 0; l < N; l++) lat[l] = 6;
        bidx = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && bidx < 3; i++) @(negedge clk);
        check("reach_batch2", bidx >= 3, 1);
        repeat (2) @(negedge clk);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sbox_in", sbox_in, 0);
        check("rst_shamt", sbox_shamt, 0);
        check("rst_drdy_i", sbox_drdy_i, 0);
        check("rst_state_out", state_out, 0);
        check("rst_key_out", key_out, 0);
        repeat (10) @(negedge clk);
        check("late_busy", busy, 0);
        check("late_done", done, 0);
        check("late_state_out", state_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int l = 0; l < N; l++) begin
            cnt[l] = 0;
            dup_pend[l] = 0;
            lat[l] = 1;
            op_l[l] = '0;
            sh_l[l] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_drdy_i", sbox_drdy_i, 0);
        check("reset_sbox_in", sbox_in, 0);
        check("reset_state_out", state_out, 0);
        check("reset_key_out", key_out, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 16; k++) st_b[k] = W'(k);
        for (int m = 0; m < 4; m++)  ky_b[m] = W'(12'hA0 + m);
        for (int l = 0; l < N; l++)  lat[l] = 3;
        run_job(0);

        lat[0] = 1; lat[1] = 5; lat[2] = 2;
        rand_data();
        run_job(0);

        dup_en = 1;
        lat[0] = 1; lat[1] = 4; lat[2] = 3;
        rand_data();
        run_job(1);
        dup_en = 0;

        for (int r = 0; r < 8; r++) begin
            rand_data();
            for (int l = 0; l < N; l++) lat[l] = int'($urandom_range(1, 6));
            noise_en = ($urandom_range(0, 1) == 1);
            dup_en   = ($urandom_range(0, 1) == 1);
            run_job($urandom_range(0, 1) == 1);
        end
        noise_en = 0;
        dup_en   = 0;

        reset_mid_run();
        rand_data();
        lat[0] = 2; lat[1] = 1; lat[2] = 4;
        run_job(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
